// File: rtl/poly_basemul_acc.sv
// NTT-domain inner product of two length-K polynomial vectors: one Kyber base
// multiplication per cycle into a 256-entry accumulator, then Barrett reduction.
module poly_basemul_acc #(
  parameter int K       = 2,
  parameter int KYBER_Q = 3329,
  parameter int QINV    = 62209,
  parameter int V       = 20159
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K*4096-1:0]   a_i,
  input  logic [K*4096-1:0]   b_i,
  output logic [4095:0]       result,
  output logic                busy,
  output logic                done
);

  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam logic signed [31:0] Q32    = 32'(KYBER_Q);
  localparam logic signed [31:0] QINV32 = 32'(QINV);
  localparam logic signed [31:0] V32    = 32'(V);

  // Montgomery-form zetas, 2^16 * 17^(2*br6(i)+1) mod q
  localparam logic [15:0] ZETAS [64] = '{
    16'd2226, 16'd430,  16'd555,  16'd843,  16'd2078, 16'd871,  16'd1550, 16'd105,
    16'd422,  16'd587,  16'd177,  16'd3094, 16'd3038, 16'd2869, 16'd1574, 16'd1653,
    16'd3083, 16'd778,  16'd1159, 16'd3182, 16'd2552, 16'd1483, 16'd2727, 16'd1119,
    16'd1739, 16'd644,  16'd2457, 16'd349,  16'd418,  16'd329,  16'd3173, 16'd3254,
    16'd817,  16'd1097, 16'd603,  16'd610,  16'd1322, 16'd2044, 16'd1864, 16'd384,
    16'd2114, 16'd3193, 16'd1218, 16'd1994, 16'd2455, 16'd220,  16'd2142, 16'd1670,
    16'd2144, 16'd1799, 16'd2051, 16'd794,  16'd1819, 16'd2475, 16'd2459, 16'd478,
    16'd3221, 16'd3021, 16'd996,  16'd991,  16'd958,  16'd1869, 16'd1522, 16'd1628
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_RED, S_DONE} state_t;

  state_t state, state_n;

  logic [K-1:0][255:0][15:0] a_q, b_q;
  logic signed [15:0]        acc [256];
  logic [255:0][15:0]        res_q;
  logic [PW-1:0]             p_cnt, p_sel;
  logic [6:0]                m_cnt;
  logic [7:0]                ev_n, od_n, hi_n, lo_n;
  logic signed [15:0]        a0, a1, b0, b1, zr, z, r0, r1;
  logic [15:0]               red0, red1;

  function automatic logic signed [15:0] fqmul(input logic signed [15:0] x,
                                               input logic signed [15:0] y);
    logic signed [31:0] mm;
    logic signed [15:0] t;
    mm = 32'(x) * 32'(y);
    t  = 16'(mm * QINV32);
    return 16'((mm - 32'(t) * Q32) >>> 16);
  endfunction

  function automatic logic [15:0] barrett(input logic signed [15:0] x);
    logic signed [31:0] t;
    t = (V32 * 32'(x)) >>> 26;
    return 16'(32'(x) - t * Q32);
  endfunction

  // Accumulator indices are natural order; packed buses store coefficient n
  // at element 255-n, which for 2m / 2m+1 is just the inverted counter.
  assign ev_n  = {m_cnt, 1'b0};
  assign od_n  = {m_cnt, 1'b1};
  assign hi_n  = {~m_cnt, 1'b1};
  assign lo_n  = {~m_cnt, 1'b0};
  assign p_sel = PW'(K - 1) - p_cnt;

  assign result = res_q;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_comb begin
    a0   = $signed(a_q[p_sel][hi_n]);
    a1   = $signed(a_q[p_sel][lo_n]);
    b0   = $signed(b_q[p_sel][hi_n]);
    b1   = $signed(b_q[p_sel][lo_n]);
    zr   = $signed(ZETAS[m_cnt[6:1]]);
    z    = m_cnt[0] ? -zr : zr;
    r0   = fqmul(fqmul(a1, b1), z) + fqmul(a0, b0);
    r1   = fqmul(a0, b1) + fqmul(a1, b0);
    red0 = barrett(acc[ev_n]);
    red1 = barrett(acc[od_n]);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: state_n = S_MUL;
      S_MUL:  if (m_cnt == 7'd127 && p_cnt == PW'(K - 1)) state_n = S_RED;
      S_RED:  if (m_cnt == 7'd127) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_cnt <= '0;
      m_cnt <= '0;
      res_q <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          p_cnt <= '0;
          m_cnt <= '0;
        end
        S_MUL: begin
          m_cnt <= m_cnt + 7'd1;
          if (m_cnt == 7'd127) p_cnt <= p_cnt + PW'(1);
        end
        S_RED: begin
          m_cnt       <= m_cnt + 7'd1;
          res_q[hi_n] <= red0;
          res_q[lo_n] <= red1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      a_q <= a_i;
      b_q <= b_i;
    end
    if (state == S_MUL) begin
      if (p_cnt == '0) begin
        acc[ev_n] <= r0;
        acc[od_n] <= r1;
      end else begin
        acc[ev_n] <= acc[ev_n] + r0;
        acc[od_n] <= acc[od_n] + r1;
      end
    end
  end

endmodule

// File: tb/tb_poly_basemul_acc.sv
// Scoreboard bench for poly_basemul_acc: directed vectors, reset/start corner
// cases and random vectors checked against a reference basemul + Barrett model.
module tb_poly_basemul_acc;

  localparam int K    = 2;
  localparam int Q    = 3329;
  localparam int QINV = 62209;
  localparam int V    = 20159;

  typedef logic [K-1:0][255:0][15:0] vec_t;

  logic          clk = 1'b0;
  logic          rst, start;
  vec_t          a_i, b_i;
  logic [4095:0] result;
  logic          busy, done;

  int            n_pass = 0;
  int            n_checks = 0;
  int            done_cnt = 0;
  int            zt [64];
  logic [4095:0] exp_q [$];

  poly_basemul_acc #(.K(K), .KYBER_Q(Q), .QINV(QINV), .V(V)) dut (
    .clk(clk), .rst(rst), .start(start), .a_i(a_i), .b_i(b_i),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int fq(int x, int y);
    int m, t;
    m = x * y;
    t = (m * QINV) & 32'h0000FFFF;
    if (t > 32767) t -= 65536;
    return (m - t * Q) >>> 16;
  endfunction

  function automatic int barrett_m(int x);
    int t;
    t = (V * x) >>> 26;
    return x - t * Q;
  endfunction

  function automatic logic [4095:0] model(vec_t a, vec_t b);
    int acc [256];
    int a0, a1, b0, b1, z;
    logic [4095:0] r;
    for (int n = 0; n < 256; n++) acc[n] = 0;
    for (int p = 0; p < K; p++) begin
      for (int m = 0; m < 128; m++) begin
        a0 = int'($signed(a[K-1-p][255-2*m]));
        a1 = int'($signed(a[K-1-p][254-2*m]));
        b0 = int'($signed(b[K-1-p][255-2*m]));
        b1 = int'($signed(b[K-1-p][254-2*m]));
        z  = (m % 2 == 0) ? zt[m/2] : -zt[m/2];
        acc[2*m]   += fq(fq(a1, b1), z) + fq(a0, b0);
        acc[2*m+1] += fq(a0, b1) + fq(a1, b0);
      end
    end
    r = '0;
    for (int n = 0; n < 256; n++) r[4095-16*n -: 16] = 16'(barrett_m(acc[n]));
    return r;
  endfunction

  function automatic int coef(logic [4095:0] x, int n);
    return int'(x[4095-16*n -: 16]);
  endfunction

  function automatic int first_diff(logic [4095:0] x, logic [4095:0] y);
    for (int n = 0; n < 256; n++)
      if (x[4095-16*n -: 16] !== y[4095-16*n -: 16]) return n;
    return 0;
  endfunction

  task automatic gen(output vec_t v);
    for (int p = 0; p < K; p++)
      for (int n = 0; n < 256; n++) v[p][n] = 16'($urandom_range(0, Q - 1));
  endtask

  task automatic launch(input vec_t a, input vec_t b);
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      tick;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_checks++;
      if ({busy, done, result} !== '0)
        $display("FAIL reset_idle[%0d]: busy=%b done=%b result_nonzero=%b, want all 0",
                 i, busy, done, |result);
      else n_pass++;
    end
    rst = 1'b1; start = 1'b1;
    tick;
    rst = 1'b0; start = 1'b0;
    tick;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_with_start: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_term;
    vec_t a, b; logic [4095:0] e, w; int lat, idx; bit bok;
    a = '0; b = '0; e = '0;
    a[K-1][255] = 16'd5; b[K-1][255] = 16'd2285;
    e[4095 -: 16] = 16'd5;
    exp_q.push_back(e);
    launch(a, b);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 385) $display("FAIL single_latency: got %0d want 385", lat); else n_pass++;
    n_checks++;
    if (bok !== 1'b1) $display("FAIL single_busy: busy dropped before done"); else n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if (result !== w) begin
      idx = first_diff(result, w);
      $display("FAIL single_result: coef%0d got %0d want %0d", idx, coef(result, idx), coef(w, idx));
    end else n_pass++;
    tick;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL single_after_done: busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_zeta_sign;
    vec_t a, b; logic [4095:0] e, w; int lat, idx; bit bok;
    a = '0; b = '0; e = '0;
    a[K-1][254] = 16'd2285; a[K-1][252] = 16'd2285;
    b = a;
    e[4095 -: 16] = 16'd2226;
    e[4063 -: 16] = 16'd1103;
    exp_q.push_back(e);
    launch(a, b);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 385) $display("FAIL zeta_latency: got %0d want 385", lat); else n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if (result !== w) begin
      idx = first_diff(result, w);
      $display("FAIL zeta_result: coef%0d got %0d want %0d", idx, coef(result, idx), coef(w, idx));
    end else n_pass++;
    tick;
  endtask

  task automatic test_accumulate;
    vec_t a, b; logic [4095:0] e, w; int lat, idx; bit bok;
    a = '0; b = '0; e = '0;
    a[1][255] = 16'd3000; a[0][255] = 16'd3000;
    b[1][255] = 16'd2285; b[0][255] = 16'd2285;
    e[4095 -: 16] = 16'd2671;
    exp_q.push_back(e);
    launch(a, b);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 385) $display("FAIL accum_latency: got %0d want 385", lat); else n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if (result !== w) begin
      idx = first_diff(result, w);
      $display("FAIL accum_result: coef%0d got %0d want %0d", idx, coef(result, idx), coef(w, idx));
    end else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid;
    vec_t a, b; logic [4095:0] e, w; int lat, idx, dc; bit bok;
    a = '0; b = '0; e = '0;
    a[K-1][255] = 16'd5; b[K-1][255] = 16'd2285;
    e[4095 -: 16] = 16'd5;
    launch(a, b);
    repeat (201) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    dc = done_cnt;
    n_checks++;
    if ({busy, done, result} !== '0)
      $display("FAIL midreset_state: busy=%b done=%b result_nonzero=%b want all 0", busy, done, |result);
    else n_pass++;
    repeat (400) tick;
    n_checks++;
    if (done_cnt !== dc) $display("FAIL midreset_no_done: got %0d done pulses want 0", done_cnt - dc);
    else n_pass++;
    exp_q.push_back(e);
    launch(a, b);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 385) $display("FAIL midreset_latency: got %0d want 385", lat); else n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if (result !== w) begin
      idx = first_diff(result, w);
      $display("FAIL midreset_result: coef%0d got %0d want %0d", idx, coef(result, idx), coef(w, idx));
    end else n_pass++;
    tick;
  endtask

  task automatic test_start_while_busy;
    vec_t a, b, junk; logic [4095:0] w; int lat, idx, dc; bit bok;
    gen(a); gen(b);
    exp_q.push_back(model(a, b));
    dc = done_cnt;
    launch(a, b);
    lat = -1; bok = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      start = (c == 50 || c == 300);
      if (c == 2) begin
        gen(junk); a_i = junk;
        gen(junk); b_i = junk;
      end
      tick;
      if (busy !== 1'b1) bok = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 385) $display("FAIL busy_start_latency: got %0d want 385", lat); else n_pass++;
    n_checks++;
    if (bok !== 1'b1) $display("FAIL busy_start_busy: busy dropped before done"); else n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if (result !== w) begin
      idx = first_diff(result, w);
      $display("FAIL busy_start_result: coef%0d got %0d want %0d", idx, coef(result, idx), coef(w, idx));
    end else n_pass++;
    repeat (400) tick;
    n_checks++;
    if (done_cnt !== dc + 1 || busy !== 1'b0)
      $display("FAIL busy_start_single_done: got %0d done pulses busy=%b want 1 and 0", done_cnt - dc, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    vec_t a, b; logic [4095:0] w; int lat, idx; bit bok, rng_ok;
    for (int v = 0; v < 20; v++) begin
      gen(a); gen(b);
      exp_q.push_back(model(a, b));
      launch(a, b);
      wait_done(lat, bok);
      n_checks++;
      if (lat !== 385) $display("FAIL rand%0d_latency: got %0d want 385", v, lat); else n_pass++;
      w = exp_q.pop_front();
      n_checks++;
      if (result !== w) begin
        idx = first_diff(result, w);
        $display("FAIL rand%0d_result: coef%0d got %0d want %0d", v, idx, coef(result, idx), coef(w, idx));
      end else n_pass++;
      rng_ok = 1'b1;
      for (int n = 0; n < 256; n++) if (coef(result, n) > Q) rng_ok = 1'b0;
      n_checks++;
      if (rng_ok !== 1'b1) $display("FAIL rand%0d_range: coefficient outside [0,%0d]", v, Q); else n_pass++;
      tick;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rand%0d_idle: busy=%b want 0", v, busy); else n_pass++;
    end
  endtask

  initial begin
    int br, z;
    for (int i = 0; i < 64; i++) begin
      br = 0;
      for (int j = 0; j < 6; j++) if (((i >> j) & 1) == 1) br |= 1 << (5 - j);
      z = 2285;
      for (int k = 0; k < 2 * br + 1; k++) z = (z * 17) % Q;
      zt[i] = z;
    end
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    test_reset;
    test_single_term;
    test_zeta_sign;
    test_accumulate;
    test_reset_mid;
    test_start_while_busy;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
